// File: rtl/store_buffer_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | riscv_pkg : store-funct3 codes, store-buffer entry, drain states    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package riscv_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // Word-address field sized for the widest supported byte address (32 bits).
    localparam int SB_WAW = 30;

    typedef struct packed {
        logic [SB_WAW-1:0] waddr;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } sb_entry_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/store_buffer_ctrl_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sb_fifo : DEPTH-entry store FIFO with wrap-bit pointers and a       |
// |           per-entry word-address compare vector. Rev 1.0            |
// +--------------------------------------------------------------------+
module sb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  sb_entry_t                wentry_i,
    input  logic [SB_WAW-1:0]        cmp_waddr_i,
    output sb_entry_t                head_o,
    output sb_entry_t                next_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [DEPTH-1:0]         match_o
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t   mem_q [DEPTH];
    logic [PW:0] wr_ptr_q;
    logic [PW:0] rd_ptr_q;
    logic [PW:0] count_q;
    logic [PW-1:0] w_next_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[PW-1:0]] <= wentry_i;
    end

    assign w_next_idx = rd_ptr_q[PW-1:0] + 1'b1;
    assign head_o     = mem_q[rd_ptr_q[PW-1:0]];
    assign next_o     = mem_q[w_next_idx];
    assign full_o     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign count_o    = count_q;

    // A slot is live when its distance from the read index is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        logic [PW-1:0] w_off;
        assign w_off      = PW'(i) - rd_ptr_q[PW-1:0];
        assign match_o[i] = ({1'b0, w_off} < count_q) && (mem_q[i].waddr == cmp_waddr_i);
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | store_buffer_ctrl : posted-write store buffer and memory drain FSM. |
// | Optional MISALIGN_TRAP_EN drops misaligned SH/SW. Rev 1.0           |
// +--------------------------------------------------------------------+
module store_buffer_ctrl
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic [2:0]    st_funct3,
    output logic          mem_req,
    output logic [AW-3:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hazard,
    output logic          busy
`ifdef MISALIGN_TRAP_EN
    ,
    output logic          st_misalign
`endif
);

    localparam int PW = $clog2(DEPTH);

    drain_state_t  state_q;
    logic          mem_req_q;
    logic [AW-3:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [3:0]    mem_be_q;

    sb_entry_t      w_entry;
    sb_entry_t      w_head;
    sb_entry_t      w_next;
    logic           w_fmt_ok;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [PW:0]    w_count;
    logic [DEPTH-1:0] w_match;
    logic           w_unused;

    always_comb begin
        w_fmt_ok      = 1'b1;
        w_entry.waddr = SB_WAW'(st_addr[AW-1:2]);
        w_entry.wdata = '0;
        w_entry.be    = '0;
        case (st_funct3)
            F3_SB: begin
                w_entry.be    = 4'b0001 << st_addr[1:0];
                w_entry.wdata = {4{st_data[7:0]}};
            end
            F3_SH: begin
                w_entry.be    = st_addr[1] ? 4'b1100 : 4'b0011;
                w_entry.wdata = {2{st_data[15:0]}};
            end
            F3_SW: begin
                w_entry.be    = 4'b1111;
                w_entry.wdata = st_data;
            end
            default: w_fmt_ok = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    logic st_misalign_q;

    assign w_misalign = ((st_funct3 == F3_SH) && st_addr[0]) ||
                        ((st_funct3 == F3_SW) && (st_addr[1:0] != 2'b00));
    assign w_push     = st_valid && st_ready && w_fmt_ok && !w_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_misalign_q <= 1'b0;
        else        st_misalign_q <= st_valid && st_ready && w_misalign;
    end
    assign st_misalign = st_misalign_q;
`else
    assign w_push = st_valid && st_ready && w_fmt_ok;
`endif

    assign w_pop = mem_req_q && mem_ack;

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_push),
        .pop_i       (w_pop),
        .wentry_i    (w_entry),
        .cmp_waddr_i (SB_WAW'(ld_addr[AW-1:2])),
        .head_o      (w_head),
        .next_o      (w_next),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count),
        .match_o     (w_match)
    );

    // The entry being requested stays in the FIFO until acked, so a pop with
    // more than one entry left can present the following slot immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!w_empty) begin
                        state_q     <= S_REQ;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= w_head.waddr[AW-3:0];
                        mem_wdata_q <= w_head.wdata;
                        mem_be_q    <= w_head.be;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        if (w_count > {{PW{1'b0}}, 1'b1}) begin
                            mem_addr_q  <= w_next.waddr[AW-3:0];
                            mem_wdata_q <= w_next.wdata;
                            mem_be_q    <= w_next.be;
                        end else begin
                            state_q   <= S_IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign st_ready  = !w_full;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign ld_hazard = ld_valid && (|w_match);
    assign busy      = !w_empty || mem_req_q;
    assign w_unused  = ^ld_addr[1:0];

endmodule
`default_nettype wire

// File: tb/tb_store_buffer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_store_buffer_ctrl : directed stimulus with a request scoreboard  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_store_buffer_ctrl;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        busy;
`ifdef MISALIGN_TRAP_EN
    logic        st_misalign;
`endif

    store_buffer_ctrl #(.DEPTH(4), .AW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_funct3 (st_funct3),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .busy      (busy)
`ifdef MISALIGN_TRAP_EN
        ,
        .st_misalign (st_misalign)
`endif
    );

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        e.a  = a[31:2];
        e.d  = d;
        e.be = be;
        sbq.push_back(e);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        st_valid  = 1'b1;
        st_addr   = a;
        st_data   = d;
        st_funct3 = f3;
        @(posedge clk); #1;
        st_valid  = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Every accepted memory request is matched against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mem_req && mem_ack) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_req: got addr %0h, no request expected", mem_addr);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sb_addr",  64'(mem_addr),  64'(e.a));
                    chk("sb_wdata", 64'(mem_wdata), 64'(e.d));
                    chk("sb_be",    64'(mem_be),    64'(e.be));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
        mem_ack = 1'b0; ld_valid = 1'b0; ld_addr = '0;
        #12;
        chk("rst_mem_req",   64'(mem_req),   64'd0);
        chk("rst_mem_addr",  64'(mem_addr),  64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_be",    64'(mem_be),    64'd0);
        chk("rst_st_ready",  64'(st_ready),  64'd1);
        chk("rst_busy",      64'(busy),      64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1);

        // SB 0x103 with ack tied high: request two cycles after the handshake
        mem_ack = 1'b1;
        exp_push(32'h103, 32'hABABABAB, 4'b1000);
        store(32'h103, 32'hAB, SB);
        @(negedge clk); chk("lat_n1_req", 64'(mem_req), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_n2_req",   64'(mem_req),   64'd1);
        chk("lat_n2_addr",  64'(mem_addr),  64'h40);
        chk("lat_n2_be",    64'(mem_be),    64'b1000);
        chk("lat_n2_wdata", 64'(mem_wdata), 64'hABABABAB);
        cyc(3);
        @(negedge clk); chk("lat_idle_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // formatting of the other store widths, plus an ignored funct3
        exp_push(32'h100, 32'h5A5A5A5A, 4'b0001);
        store(32'h100, 32'h0000005A, SB);
        exp_push(32'h106, 32'hBEEFBEEF, 4'b1100);
        store(32'h106, 32'h1234BEEF, SH);
        store(32'h108, 32'h1, 3'b011);
        exp_push(32'h10C, 32'hDEADBEEF, 4'b1111);
        store(32'h10C, 32'hDEADBEEF, SW);
        cyc(8);
        @(negedge clk);
        chk("fmt_drained_busy", 64'(busy), 64'd0);
        chk("fmt_sbq_empty",    64'(sbq.size()), 64'd0);
        @(posedge clk); #1;
        store(32'h108, 32'h1, 3'b011);
        cyc(3);
        @(negedge clk);
        chk("bad_f3_busy",  64'(busy),     64'd0);
        chk("bad_f3_ready", 64'(st_ready), 64'd1);
        @(posedge clk); #1;

        // fill with ack low, fifth store refused, then back-to-back drain
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_push(32'h10 + 32'(4*i), 32'h1000 + 32'(i), 4'b1111);
            store(32'h10 + 32'(4*i), 32'h1000 + 32'(i), SW);
        end
        @(negedge clk);
        chk("full_ready", 64'(st_ready), 64'd0);
        chk("full_busy",  64'(busy),     64'd1);
        @(posedge clk); #1;
        store(32'h20, 32'h5555, SW);
        @(negedge clk);
        chk("full_5th_ready", 64'(st_ready), 64'd0);
        chk("full_req_held",  64'(mem_req),  64'd1);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("b2b_req", 64'(mem_req), 64'd1);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        @(negedge clk);
        chk("b2b_done_req",  64'(mem_req),     64'd0);
        chk("b2b_done_busy", 64'(busy),        64'd0);
        chk("b2b_sbq_empty", 64'(sbq.size()),  64'd0);
        @(posedge clk); #1;

        // full buffer: ack and store in the same cycle pops only
        for (int i = 0; i < 4; i++) begin
            exp_push(32'h30 + 32'(4*i), 32'h3000 + 32'(i), 4'b1111);
            store(32'h30 + 32'(4*i), 32'h3000 + 32'(i), SW);
        end
        exp_push(32'h100, 32'h77, 4'b1111);
        mem_ack = 1'b1; st_valid = 1'b1; st_addr = 32'h100; st_data = 32'h77; st_funct3 = SW;
        @(negedge clk); chk("simul_ready0", 64'(st_ready), 64'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk); chk("simul_ready_next", 64'(st_ready), 64'd1);
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk); chk("simul_full_again", 64'(st_ready), 64'd0);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        for (int i = 0; i < 20 && busy; i++) cyc(1);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("simul_drain_busy", 64'(busy),       64'd0);
        chk("simul_sbq_empty",  64'(sbq.size()), 64'd0);
        @(posedge clk); #1;

        // load hazard against a pending and then in-flight store
        exp_push(32'h200, 32'h11223344, 4'b1111);
        store(32'h200, 32'h11223344, SW);
        ld_valid = 1'b1; ld_addr = 32'h202;
        @(negedge clk); chk("hz_same_word", 64'(ld_hazard), 64'd1);
        @(posedge clk); #1;
        ld_addr = 32'h204;
        @(negedge clk); chk("hz_next_word", 64'(ld_hazard), 64'd0);
        @(posedge clk); #1;
        ld_valid = 1'b0; ld_addr = 32'h200;
        @(negedge clk); chk("hz_no_load", 64'(ld_hazard), 64'd0);
        @(posedge clk); #1;
        ld_valid = 1'b1; ld_addr = 32'h203;
        @(negedge clk);
        chk("hz_inflight_req", 64'(mem_req),   64'd1);
        chk("hz_inflight",     64'(ld_hazard), 64'd1);

        // asynchronous reset abandons the outstanding request
        rst_n = 1'b0;
        #1;
        chk("arst_req",   64'(mem_req),   64'd0);
        chk("arst_busy",  64'(busy),      64'd0);
        chk("arst_ready", 64'(st_ready),  64'd1);
        chk("arst_addr",  64'(mem_addr),  64'd0);
        chk("arst_hz",    64'(ld_hazard), 64'd0);
        sbq.delete();
        ld_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(3);
        @(negedge clk); chk("arst_nothing_left", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // misaligned halfword
        mem_ack = 1'b1;
`ifdef MISALIGN_TRAP_EN
        store(32'h101, 32'h1234, SH);
        @(negedge clk); chk("mis_pulse", 64'(st_misalign), 64'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("mis_pulse_end", 64'(st_misalign), 64'd0);
        cyc(3);
        @(negedge clk); chk("mis_no_req", 64'(busy), 64'd0);
`else
        exp_push(32'h101, 32'h12341234, 4'b0011);
        store(32'h101, 32'h1234, SH);
        cyc(6);
        @(negedge clk);
        chk("mis_drain_busy", 64'(busy),       64'd0);
        chk("mis_sbq_empty",  64'(sbq.size()), 64'd0);
`endif
        mem_ack = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
